// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the VGA/LCD raster timing generator:
//   - axis_timing_t : one axis worth of timing fields (disp, fporch, sync, bporch)
//                     held at MAX_W bits so the helpers work for any W <= MAX_W
//   - *_640 / *_480 : reset timing constants for 640x480@60
//   - axis_total()  : DISP+FP+SYNC+BP with two guard bits
//   - axis_valid()  : acceptance test for a requested axis timing at width w
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  // Widest timing field the helpers are sized for; the core's W must not exceed it.
  localparam int unsigned MAX_W = 16;

  typedef struct packed {
    logic [MAX_W-1:0] disp;
    logic [MAX_W-1:0] fporch;
    logic [MAX_W-1:0] sync;
    logic [MAX_W-1:0] bporch;
  } axis_timing_t;

  // 640x480@60 (25.175 MHz pixel clock)
  localparam int unsigned H_DISP_640 = 640;
  localparam int unsigned H_FP_640   = 16;
  localparam int unsigned H_SYNC_640 = 96;
  localparam int unsigned H_BP_640   = 48;
  localparam int unsigned V_DISP_480 = 480;
  localparam int unsigned V_FP_480   = 10;
  localparam int unsigned V_SYNC_480 = 2;
  localparam int unsigned V_BP_480   = 33;

  // Full line/frame length; two extra bits so four maximal fields cannot overflow.
  function automatic logic [MAX_W+1:0] axis_total(input axis_timing_t t);
    return {2'b00, t.disp} + {2'b00, t.fporch} + {2'b00, t.sync} + {2'b00, t.bporch};
  endfunction

  // An axis is usable when it has a visible region, a sync pulse, and its
  // total still fits a W-bit counter (TOTAL <= 2^w).
  function automatic logic axis_valid(input axis_timing_t t, input int unsigned w);
    logic [MAX_W+1:0] limit;
    limit = {{(MAX_W+1){1'b0}}, 1'b1} << w;
    return (t.disp != '0) && (t.sync != '0) && (axis_total(t) <= limit);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One raster axis: a counter over [0, TOTAL) with region decode.
// Region order: front porch, sync, back porch, display.
// Ports:
//   clk, rst_n        pixel clock, asynchronous active-low reset
//   en                advance the counter this cycle
//   disp/fporch/sync/bporch  live timing for this axis (W bits each)
//   first             counter is 0
//   last              counter is TOTAL-1 (wraps on the next enabled edge)
//   in_sync, in_disp  counter lies in the sync / display region
//   coord             offset into the display region, 0 outside it
// All decode outputs are combinational from the counter register.
// -----------------------------------------------------------------------------
module vga_axis_counter #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] disp,
  input  logic [W-1:0] fporch,
  input  logic [W-1:0] sync,
  input  logic [W-1:0] bporch,
  output logic         first,
  output logic         last,
  output logic         in_sync,
  output logic         in_disp,
  output logic [W-1:0] coord
);

  localparam int unsigned TW = W + 2;

  logic [W-1:0]  cnt;
  logic [TW-1:0] cnt_ext;
  logic [TW-1:0] sync_start;
  logic [TW-1:0] sync_end;
  logic [TW-1:0] disp_start;
  logic [TW-1:0] total;

  // Region boundaries and decode of the current count.
  always_comb begin
    cnt_ext    = {2'b00, cnt};
    sync_start = {2'b00, fporch};
    sync_end   = sync_start + {2'b00, sync};
    disp_start = sync_end + {2'b00, bporch};
    total      = disp_start + {2'b00, disp};
    first      = (cnt == '0);
    last       = (cnt_ext == (total - {{(TW-1){1'b0}}, 1'b1}));
    in_sync    = (cnt_ext >= sync_start) && (cnt_ext < sync_end);
    in_disp    = (cnt_ext >= disp_start);
    if (in_disp) begin
      coord = W'(cnt_ext - disp_start);
    end else begin
      coord = '0;
    end
  end

  // Position counter: advances on enable, wraps to 0 after TOTAL-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      if (last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + {{(W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/vga_timing_core.sv
// -----------------------------------------------------------------------------
// vga_timing_core
// Runtime-programmable VGA/LCD raster timing generator (single pixel clock).
// Requested timing is validated on cfg_load, held in a pending buffer and
// copied into the live timing only at the last pixel of a frame.
//
// Ports:
//   pixel_clk, rst_n          clock (rising edge), asynchronous active-low reset
//   cfg_h_* / cfg_v_*         requested timing fields (W bits each)
//   cfg_load                  one-cycle strobe capturing cfg_* if valid
//   cfg_pending               accepted timing waiting for the frame boundary
//   cfg_err                   last cfg_load rejected (sticky until a good load)
//   vga_hs, vga_vs            sync outputs, pulse level HS_POL / VS_POL
//   vga_de                    active video enable
//   pix_x, pix_y              active-area coordinate, 0 while vga_de is low
//   line_start, frame_start   one-cycle strobes at h=0 / h=0,v=0
//   frame_cnt                 (VGA_TIMING_FRAME_CNT_EN only) 16-bit frame count
//
// Build option: define VGA_TIMING_FRAME_CNT_EN to add the frame_cnt output.
// All outputs are registered one cycle behind the counters. The counters hold
// at 0 for the first edge after reset so the first frame_start is a clean
// one-cycle pulse on the second edge.
// -----------------------------------------------------------------------------
module vga_timing_core
  import vga_timing_pkg::*;
#(
  parameter int unsigned W          = 12,
  parameter logic        HS_POL     = 1'b0,
  parameter logic        VS_POL     = 1'b0,
  parameter int unsigned H_DISP_RST = H_DISP_640,
  parameter int unsigned H_FP_RST   = H_FP_640,
  parameter int unsigned H_SYNC_RST = H_SYNC_640,
  parameter int unsigned H_BP_RST   = H_BP_640,
  parameter int unsigned V_DISP_RST = V_DISP_480,
  parameter int unsigned V_FP_RST   = V_FP_480,
  parameter int unsigned V_SYNC_RST = V_SYNC_480,
  parameter int unsigned V_BP_RST   = V_BP_480
) (
  input  logic         pixel_clk,
  input  logic         rst_n,
  input  logic [W-1:0] cfg_h_disp,
  input  logic [W-1:0] cfg_h_fporch,
  input  logic [W-1:0] cfg_h_sync,
  input  logic [W-1:0] cfg_h_bporch,
  input  logic [W-1:0] cfg_v_disp,
  input  logic [W-1:0] cfg_v_fporch,
  input  logic [W-1:0] cfg_v_sync,
  input  logic [W-1:0] cfg_v_bporch,
  input  logic         cfg_load,
  output logic         cfg_pending,
  output logic         cfg_err,
  output logic         vga_hs,
  output logic         vga_vs,
  output logic         vga_de,
  output logic [W-1:0] pix_x,
  output logic [W-1:0] pix_y,
  output logic         line_start,
  output logic         frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0]  frame_cnt
`endif
);

  typedef struct packed {
    logic [W-1:0] disp;
    logic [W-1:0] fporch;
    logic [W-1:0] sync;
    logic [W-1:0] bporch;
  } timing_t;

  localparam timing_t H_RST = '{disp: W'(H_DISP_RST), fporch: W'(H_FP_RST),
                                sync: W'(H_SYNC_RST), bporch: W'(H_BP_RST)};
  localparam timing_t V_RST = '{disp: W'(V_DISP_RST), fporch: W'(V_FP_RST),
                                sync: W'(V_SYNC_RST), bporch: W'(V_BP_RST)};

  logic         run;
  timing_t      h_act, v_act, h_pend, v_pend;
  timing_t      h_cfg, v_cfg;
  axis_timing_t h_req, v_req;
  logic         cfg_ok, apply, pending_nxt, err_nxt;
  logic         h_first, h_last, h_in_sync, h_in_disp;
  logic         v_first, v_last, v_in_sync, v_in_disp;
  logic [W-1:0] h_coord, v_coord;
  logic         de_nxt;

  // Counters stay parked at 0 for the first edge after reset.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  // Request validation and pending/error next-state.
  always_comb begin
    h_cfg = '{disp: cfg_h_disp, fporch: cfg_h_fporch, sync: cfg_h_sync, bporch: cfg_h_bporch};
    v_cfg = '{disp: cfg_v_disp, fporch: cfg_v_fporch, sync: cfg_v_sync, bporch: cfg_v_bporch};
    h_req = '{disp: MAX_W'(cfg_h_disp), fporch: MAX_W'(cfg_h_fporch),
              sync: MAX_W'(cfg_h_sync), bporch: MAX_W'(cfg_h_bporch)};
    v_req = '{disp: MAX_W'(cfg_v_disp), fporch: MAX_W'(cfg_v_fporch),
              sync: MAX_W'(cfg_v_sync), bporch: MAX_W'(cfg_v_bporch)};
    cfg_ok = axis_valid(h_req, W) && axis_valid(v_req, W);
    // Last pixel of the frame: the only point where live timing may change.
    apply  = run && h_last && v_last;
    pending_nxt = cfg_pending;
    err_nxt     = cfg_err;
    if (cfg_load && cfg_ok) begin
      // A load on the apply cycle becomes pending for the following frame.
      pending_nxt = 1'b1;
      err_nxt     = 1'b0;
    end else if (cfg_load) begin
      pending_nxt = cfg_pending && !apply;
      err_nxt     = 1'b1;
    end else if (apply) begin
      pending_nxt = 1'b0;
    end else begin
      pending_nxt = cfg_pending;
    end
  end

  // Live and pending timing registers.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_act       <= H_RST;
      v_act       <= V_RST;
      h_pend      <= H_RST;
      v_pend      <= V_RST;
      cfg_pending <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      if (apply && cfg_pending) begin
        h_act <= h_pend;
        v_act <= v_pend;
      end
      if (cfg_load && cfg_ok) begin
        h_pend <= h_cfg;
        v_pend <= v_cfg;
      end
      cfg_pending <= pending_nxt;
      cfg_err     <= err_nxt;
    end
  end

  vga_axis_counter #(.W(W)) u_h_axis (
    .clk     (pixel_clk),
    .rst_n   (rst_n),
    .en      (run),
    .disp    (h_act.disp),
    .fporch  (h_act.fporch),
    .sync    (h_act.sync),
    .bporch  (h_act.bporch),
    .first   (h_first),
    .last    (h_last),
    .in_sync (h_in_sync),
    .in_disp (h_in_disp),
    .coord   (h_coord)
  );

  // Vertical axis steps on the horizontal wrap, so vga_vs only moves at line start.
  vga_axis_counter #(.W(W)) u_v_axis (
    .clk     (pixel_clk),
    .rst_n   (rst_n),
    .en      (run && h_last),
    .disp    (v_act.disp),
    .fporch  (v_act.fporch),
    .sync    (v_act.sync),
    .bporch  (v_act.bporch),
    .first   (v_first),
    .last    (v_last),
    .in_sync (v_in_sync),
    .in_disp (v_in_disp),
    .coord   (v_coord)
  );

  assign de_nxt = h_in_disp && v_in_disp;

  // Registered video outputs, one cycle behind the counters.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_hs      <= ~HS_POL;
      vga_vs      <= ~VS_POL;
      vga_de      <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (run) begin
      vga_hs      <= h_in_sync ? HS_POL : ~HS_POL;
      vga_vs      <= v_in_sync ? VS_POL : ~VS_POL;
      vga_de      <= de_nxt;
      pix_x       <= de_nxt ? h_coord : '0;
      pix_y       <= de_nxt ? v_coord : '0;
      line_start  <= h_first;
      frame_start <= h_first && v_first;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Frame counter, stepping on the same edge that raises frame_start.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= 16'd0;
    end else if (run && h_first && v_first) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_core.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_core
// Directed bench for vga_timing_core using a reduced raster:
//   reset timing H: disp 8, fp 2, sync 3, bp 1 (total 14)
//                V: disp 4, fp 1, sync 2, bp 1 (total 8, frame 112 cycles)
//   HS_POL=0 (active-low hsync), VS_POL=1 (active-high vsync), W=8.
// Outputs after post-release edge k show pixel p=k-2 (k>=2) of the frame.
// -----------------------------------------------------------------------------
module tb_vga_timing_core;

  localparam int unsigned W = 8;

  logic         pixel_clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] cfg_h_disp, cfg_h_fporch, cfg_h_sync, cfg_h_bporch;
  logic [W-1:0] cfg_v_disp, cfg_v_fporch, cfg_v_sync, cfg_v_bporch;
  logic         cfg_load;
  logic         cfg_pending, cfg_err;
  logic         vga_hs, vga_vs, vga_de;
  logic [W-1:0] pix_x, pix_y;
  logic         line_start, frame_start;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0]  frame_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 pixel_clk = ~pixel_clk;

  vga_timing_core #(
    .W(W), .HS_POL(1'b0), .VS_POL(1'b1),
    .H_DISP_RST(8), .H_FP_RST(2), .H_SYNC_RST(3), .H_BP_RST(1),
    .V_DISP_RST(4), .V_FP_RST(1), .V_SYNC_RST(2), .V_BP_RST(1)
  ) dut (
    .pixel_clk    (pixel_clk),
    .rst_n        (rst_n),
    .cfg_h_disp   (cfg_h_disp),
    .cfg_h_fporch (cfg_h_fporch),
    .cfg_h_sync   (cfg_h_sync),
    .cfg_h_bporch (cfg_h_bporch),
    .cfg_v_disp   (cfg_v_disp),
    .cfg_v_fporch (cfg_v_fporch),
    .cfg_v_sync   (cfg_v_sync),
    .cfg_v_bporch (cfg_v_bporch),
    .cfg_load     (cfg_load),
    .cfg_pending  (cfg_pending),
    .cfg_err      (cfg_err),
    .vga_hs       (vga_hs),
    .vga_vs       (vga_vs),
    .vga_de       (vga_de),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .line_start   (line_start),
    .frame_start  (frame_start)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .frame_cnt    (frame_cnt)
`endif
  );

  typedef struct {
    int   k;
    logic hs, vs, de;
    int   px, py;
    logic ls, fs;
    int   fc;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge pixel_clk);
    #1;
    cyc++;
  endtask

  task automatic load_cfg(input int hd, input int hf, input int hs, input int hb,
                          input int vd, input int vf, input int vs, input int vb);
    cfg_h_disp = W'(hd); cfg_h_fporch = W'(hf); cfg_h_sync = W'(hs); cfg_h_bporch = W'(hb);
    cfg_v_disp = W'(vd); cfg_v_fporch = W'(vf); cfg_v_sync = W'(vs); cfg_v_bporch = W'(vb);
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic wait_fs(input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!frame_start && n < 400);
    check({name, "_wait_fs"}, frame_start, 1);
  endtask

  // From a frame_start sample, run to the next one and tally the frame.
  task automatic measure_frame(input string name, input int exp_len, input int exp_ls,
                               input int exp_de, input int exp_hs_lo, input int exp_vs_hi);
    int n, n_ls, n_de, n_hs, n_vs;
    n = 0; n_ls = 0; n_de = 0; n_hs = 0; n_vs = 0;
    do begin
      tick();
      n++;
      if (line_start) n_ls++;
      if (vga_de)     n_de++;
      if (!vga_hs)    n_hs++;
      if (vga_vs)     n_vs++;
    end while (!frame_start && n < 400);
    check({name, "_len"},   n,    exp_len);
    check({name, "_lines"}, n_ls, exp_ls);
    check({name, "_de"},    n_de, exp_de);
    if (exp_hs_lo >= 0) check({name, "_hs_low"}, n_hs, exp_hs_lo);
    if (exp_vs_hi >= 0) check({name, "_vs_high"}, n_vs, exp_vs_hi);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //          k    hs    vs    de    px py ls    fs    fc
    vecs[0]  = '{1,   1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0};
    vecs[1]  = '{2,   1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 1};
    vecs[2]  = '{3,   1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1};
    vecs[3]  = '{4,   1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1};
    vecs[4]  = '{6,   1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1};
    vecs[5]  = '{7,   1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1};
    vecs[6]  = '{8,   1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1};
    vecs[7]  = '{16,  1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1};
    vecs[8]  = '{29,  1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1};
    vecs[9]  = '{30,  1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 1'b0, 1};
    vecs[10] = '{44,  1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1};
    vecs[11] = '{60,  1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1};
    vecs[12] = '{64,  1'b1, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1};
    vecs[13] = '{71,  1'b1, 1'b0, 1'b1, 7, 0, 1'b0, 1'b0, 1};
    vecs[14] = '{72,  1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1};
    vecs[15] = '{80,  1'b1, 1'b0, 1'b1, 2, 1, 1'b0, 1'b0, 1};
    vecs[16] = '{113, 1'b1, 1'b0, 1'b1, 7, 3, 1'b0, 1'b0, 1};
    vecs[17] = '{114, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b1, 2};
    vecs[18] = '{115, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 2};

    rst_n    = 1'b0;
    cfg_load = 1'b0;
    cfg_h_disp = 8'd8; cfg_h_fporch = 8'd2; cfg_h_sync = 8'd3; cfg_h_bporch = 8'd1;
    cfg_v_disp = 8'd4; cfg_v_fporch = 8'd1; cfg_v_sync = 8'd2; cfg_v_bporch = 8'd1;
    repeat (3) @(posedge pixel_clk);
    #1;
    check("rst_hs", vga_hs, 1);
    check("rst_vs", vga_vs, 0);
    check("rst_de", vga_de, 0);
    check("rst_px", pix_x, 0);
    check("rst_py", pix_y, 0);
    check("rst_ls", line_start, 0);
    check("rst_fs", frame_start, 0);
    check("rst_pend", cfg_pending, 0);
    check("rst_err", cfg_err, 0);

    @(negedge pixel_clk);
    rst_n = 1'b1;
    cyc   = 0;

    // Raster walk through the first frame and into the second.
    for (int i = 0; i < NV; i++) begin
      while (cyc < vecs[i].k) tick();
      check($sformatf("vec%0d_hs", vecs[i].k), vga_hs, vecs[i].hs);
      check($sformatf("vec%0d_vs", vecs[i].k), vga_vs, vecs[i].vs);
      check($sformatf("vec%0d_de", vecs[i].k), vga_de, vecs[i].de);
      check($sformatf("vec%0d_px", vecs[i].k), pix_x, vecs[i].px);
      check($sformatf("vec%0d_py", vecs[i].k), pix_y, vecs[i].py);
      check($sformatf("vec%0d_ls", vecs[i].k), line_start, vecs[i].ls);
      check($sformatf("vec%0d_fs", vecs[i].k), frame_start, vecs[i].fs);
`ifdef VGA_TIMING_FRAME_CNT_EN
      check($sformatf("vec%0d_fc", vecs[i].k), frame_cnt, vecs[i].fc);
`endif
    end

    // Whole-frame tallies at reset timing.
    wait_fs("rstfrm");
    measure_frame("rstfrm", 112, 8, 32, 24, 28);

    // Async reset mid-line with a pending config that must be discarded.
    load_cfg(6, 1, 2, 1, 3, 1, 1, 1);
    check("pre_rst_pend", cfg_pending, 1);
    tick();
    tick();
    check("pre_rst_hs", vga_hs, 0);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_hs", vga_hs, 1);
    check("async_vs", vga_vs, 0);
    check("async_de", vga_de, 0);
    check("async_pend", cfg_pending, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("async_fc", frame_cnt, 0);
`endif
    repeat (3) @(posedge pixel_clk);
    @(negedge pixel_clk);
    rst_n = 1'b1;
    tick();
    check("rel_e1_fs", frame_start, 0);
    check("rel_e1_ls", line_start, 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("rel_e1_fc", frame_cnt, 0);
`endif
    tick();
    check("rel_e2_fs", frame_start, 1);
    check("rel_e2_ls", line_start, 1);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("rel_e2_fc", frame_cnt, 1);
`endif
    measure_frame("rel_f1", 112, 8, 32, 24, 28);
    measure_frame("rel_f2", 112, 8, 32, 24, 28);

    // Rejected load (h_sync = 0) leaves timing and pending alone.
    load_cfg(6, 1, 0, 1, 3, 1, 1, 1);
    check("bad_err", cfg_err, 1);
    check("bad_pend", cfg_pending, 0);
    wait_fs("bad");
    measure_frame("bad_frm", 112, 8, 32, 24, 28);

    // Accepted load mid-frame; applies at the next frame boundary.
    load_cfg(6, 1, 2, 1, 3, 1, 1, 1);
    check("b_err", cfg_err, 0);
    check("b_pend", cfg_pending, 1);
    repeat (5) tick();
    check("b_pend_hold", cfg_pending, 1);
    wait_fs("b");
    check("b_pend_clr", cfg_pending, 0);
    measure_frame("b_frm", 60, 6, 18, 12, 10);

    // TOTAL limit 2^W: 256 accepted, 257 and zero disp rejected, last good load wins.
    load_cfg(200, 20, 20, 16, 4, 1, 2, 1);
    check("lim256_err", cfg_err, 0);
    check("lim256_pend", cfg_pending, 1);
    load_cfg(201, 20, 20, 16, 4, 1, 2, 1);
    check("lim257_err", cfg_err, 1);
    check("lim257_pend", cfg_pending, 1);
    load_cfg(8, 2, 3, 1, 0, 1, 2, 1);
    check("vdisp0_err", cfg_err, 1);
    load_cfg(8, 2, 3, 1, 4, 1, 2, 1);
    check("a_err", cfg_err, 0);
    check("a_pend", cfg_pending, 1);
    wait_fs("a");
    check("a_pend_clr", cfg_pending, 0);
    measure_frame("a_frm", 112, 8, 32, 24, 28);

    // Load coinciding with the apply edge: old pending applies, new stays pending.
    load_cfg(6, 1, 2, 1, 3, 1, 1, 1);
    repeat (109) tick();
    load_cfg(4, 1, 1, 1, 2, 1, 1, 1);
    tick();
    check("co_fs", frame_start, 1);
    check("co_pend", cfg_pending, 1);
    measure_frame("co_b", 60, 6, 18, 12, 10);
    check("co_pend_clr", cfg_pending, 0);
    measure_frame("co_c", 35, 5, 8, 5, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
